// File: rtl/pipeline_control_pkg.sv
// Purpose: shared types and helpers for the pipeline stall/flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   ctrl_state_t  - sequencer FSM encoding (RUN / FLUSH / SLEEP)
//   stage_vec_t   - one bit per stage that the sequencer can stall or invalidate
//   reg_hazard    - non-zero register match used by the load-use compare
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_FLUSH = 2'd1,
        CTRL_SLEEP = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
        logic memory;
    } stage_vec_t;

    // x0 is hardwired to zero, so a load "writing" x0 never creates a hazard.
    function automatic logic reg_hazard(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Purpose: bundles hazard inputs and stall/invalidate outputs of the sequencer.
// Latency: n/a (wires only).
// Backpressure: n/a.
//
// Modports:
//   master - the sequencer: samples hazard/commit inputs, drives stall/invalidate/pulses
//   slave  - the pipeline side: drives hazard/commit inputs, samples sequencer outputs
interface pipeline_control_if;

    // hazard and commit sources
    logic       valid_decode;
    logic [4:0] rs1_address_decode;
    logic [4:0] rs2_address_decode;
    logic       valid_execute;
    logic       load_execute;
    logic [4:0] rd_address_execute;
    logic       branch_taken;
    logic       mem_busy;
    logic       exception_memory;
    logic       mret_memory;
    logic       wfi_memory;
    logic       interrupt_pending;

    // per-stage controls
    logic       stall_fetch;
    logic       stall_decode;
    logic       stall_execute;
    logic       stall_memory;
    logic       invalidate_fetch;
    logic       invalidate_decode;
    logic       invalidate_execute;
    logic       invalidate_memory;

    // commit pulses and status
    logic       trap_commit;
    logic       mret_commit;
    logic       sleeping;

    modport master (
        input  valid_decode, rs1_address_decode, rs2_address_decode,
        input  valid_execute, load_execute, rd_address_execute,
        input  branch_taken, mem_busy, exception_memory, mret_memory,
        input  wfi_memory, interrupt_pending,
        output stall_fetch, stall_decode, stall_execute, stall_memory,
        output invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory,
        output trap_commit, mret_commit, sleeping
    );

    modport slave (
        output valid_decode, rs1_address_decode, rs2_address_decode,
        output valid_execute, load_execute, rd_address_execute,
        output branch_taken, mem_busy, exception_memory, mret_memory,
        output wfi_memory, interrupt_pending,
        input  stall_fetch, stall_decode, stall_execute, stall_memory,
        input  invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory,
        input  trap_commit, mret_commit, sleeping
    );

endinterface

// File: rtl/pipeline_control_load_use_detect.sv
// Purpose: flags a load in execute whose destination feeds the instruction in decode.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides what to do with the hazard flag.
//
// Ports:
//   valid_decode_i, rs1_address_i, rs2_address_i   - instruction in decode
//   valid_execute_i, load_execute_i, rd_address_i  - instruction in execute
//   hazard_o                                       - decode must wait one cycle
module pipeline_control_load_use_detect
    import pipeline_control_pkg::*;
(
    input  logic       valid_decode_i,
    input  logic [4:0] rs1_address_i,
    input  logic [4:0] rs2_address_i,
    input  logic       valid_execute_i,
    input  logic       load_execute_i,
    input  logic [4:0] rd_address_i,
    output logic       hazard_o
);

    logic src_match;

    assign src_match = reg_hazard(rd_address_i, rs1_address_i)
                     | reg_hazard(rd_address_i, rs2_address_i);

    assign hazard_o = valid_execute_i & load_execute_i & valid_decode_i & src_match;

endmodule

// File: rtl/pipeline_control.sv
// Purpose: central stall/flush sequencer for the 5-stage pipeline (trap/mret/wfi FSM).
// Latency: all outputs combinational from current state and inputs; only state/counter registered.
// Backpressure: mem_busy freezes every stage and holds lower-priority hazards for re-evaluation.
//
// Ports:
//   clk, reset - pipeline clock, asynchronous active-high reset
//   ctl        - pipeline_control_if.master: hazard/commit inputs in, stall/invalidate/pulses out
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_control_if.master  ctl
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       load_use;
    logic       commit_req;
    stage_vec_t stall, inv;
    logic       trap_pulse, mret_pulse, sleep_flag;

    pipeline_control_load_use_detect u_load_use (
        .valid_decode_i  (ctl.valid_decode),
        .rs1_address_i   (ctl.rs1_address_decode),
        .rs2_address_i   (ctl.rs2_address_decode),
        .valid_execute_i (ctl.valid_execute),
        .load_execute_i  (ctl.load_execute),
        .rd_address_i    (ctl.rd_address_execute),
        .hazard_o        (load_use)
    );

    assign commit_req = ctl.exception_memory | ctl.mret_memory;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CTRL_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CTRL_RUN: begin
                if (commit_req) begin
                    // The commit cycle itself invalidates, so the counter is
                    // loaded one short to give FLUSH_CYCLES extra flush cycles.
                    state_d = CTRL_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end else if (ctl.wfi_memory && !ctl.interrupt_pending) begin
                    state_d = CTRL_SLEEP;
                end
            end
            CTRL_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = CTRL_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CTRL_SLEEP: begin
                if (ctl.interrupt_pending) begin
                    state_d = CTRL_RUN;
                end
            end
            default: begin
                state_d = CTRL_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        stall      = '0;
        inv        = '0;
        trap_pulse = 1'b0;
        mret_pulse = 1'b0;
        sleep_flag = 1'b0;
        if (reset) begin
            // Every stage emits bubbles while reset is held so nothing
            // half-formed leaks out of the pipeline registers.
            inv = '1;
        end else begin
            unique case (state_q)
                CTRL_RUN: begin
                    if (ctl.exception_memory) begin
                        trap_pulse = 1'b1;
                        inv        = '1;
                    end else if (ctl.mret_memory) begin
                        mret_pulse = 1'b1;
                        inv        = '1;
                    end else if (ctl.wfi_memory) begin
                        inv = '1;
                    end else if (ctl.mem_busy) begin
                        // Freeze everything; a pending branch or load-use in
                        // execute stays put and is resolved once memory frees.
                        stall      = '1;
                        inv.memory = 1'b1;
                    end else if (ctl.branch_taken) begin
                        // Wrong-path instructions are killed, so any load-use
                        // against decode is moot.
                        inv.fetch  = 1'b1;
                        inv.decode = 1'b1;
                    end else if (load_use) begin
                        stall.fetch   = 1'b1;
                        stall.decode  = 1'b1;
                        inv.execute   = 1'b1;
                    end
                end
                CTRL_FLUSH: begin
                    inv = '1;
                end
                CTRL_SLEEP: begin
                    stall.fetch   = 1'b1;
                    stall.decode  = 1'b1;
                    stall.execute = 1'b1;
                    inv.memory    = 1'b1;
                    sleep_flag    = 1'b1;
                end
                default: begin
                    inv = '1;
                end
            endcase
        end
    end

    assign ctl.stall_fetch        = stall.fetch;
    assign ctl.stall_decode       = stall.decode;
    assign ctl.stall_execute      = stall.execute;
    assign ctl.stall_memory       = stall.memory;
    assign ctl.invalidate_fetch   = inv.fetch;
    assign ctl.invalidate_decode  = inv.decode;
    assign ctl.invalidate_execute = inv.execute;
    assign ctl.invalidate_memory  = inv.memory;
    assign ctl.trap_commit        = trap_pulse;
    assign ctl.mret_commit        = mret_pulse;
    assign ctl.sleeping           = sleep_flag;

endmodule

// File: tb/tb_pipeline_control.sv
// Purpose: directed bench for the pipeline stall/flush sequencer.
// Latency: outputs checked on the falling edge, inputs changed 1 time unit after the rising edge.
// Backpressure: mem_busy / load-use / branch / trap / mret / wfi sequences with hand-derived vectors.
module tb_pipeline_control;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    pipeline_control_if bus ();

    pipeline_control #(.FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout:
    // [10:7] stall f/d/e/m, [6:3] invalidate f/d/e/m, [2] trap, [1] mret, [0] sleeping
    localparam logic [10:0] O_IDLE  = 11'b0000_0000_000;
    localparam logic [10:0] O_RST   = 11'b0000_1111_000;
    localparam logic [10:0] O_LU    = 11'b1100_0010_000;
    localparam logic [10:0] O_BR    = 11'b0000_1100_000;
    localparam logic [10:0] O_TRAP  = 11'b0000_1111_100;
    localparam logic [10:0] O_MRET  = 11'b0000_1111_010;
    localparam logic [10:0] O_FLUSH = 11'b0000_1111_000;
    localparam logic [10:0] O_BUSY  = 11'b1111_0001_000;
    localparam logic [10:0] O_SLEEP = 11'b1110_0001_001;

    function automatic logic [10:0] outs();
        return {bus.stall_fetch, bus.stall_decode, bus.stall_execute, bus.stall_memory,
                bus.invalidate_fetch, bus.invalidate_decode, bus.invalidate_execute,
                bus.invalidate_memory, bus.trap_commit, bus.mret_commit, bus.sleeping};
    endfunction

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // sample on the falling edge, away from the state update
    task automatic chk(input string tag, input logic [10:0] exp);
        @(negedge clk);
        check(tag, outs(), exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.valid_decode       = 1'b0;
        bus.rs1_address_decode = 5'd0;
        bus.rs2_address_decode = 5'd0;
        bus.valid_execute      = 1'b0;
        bus.load_execute       = 1'b0;
        bus.rd_address_execute = 5'd0;
        bus.branch_taken       = 1'b0;
        bus.mem_busy           = 1'b0;
        bus.exception_memory   = 1'b0;
        bus.mret_memory        = 1'b0;
        bus.wfi_memory         = 1'b0;
        bus.interrupt_pending  = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.valid_execute      = 1'b1;
        bus.load_execute       = 1'b1;
        bus.rd_address_execute = rd;
        bus.valid_decode       = 1'b1;
        bus.rs1_address_decode = rs1;
        bus.rs2_address_decode = rs2;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        clear_in();

        chk("reset_outputs", O_RST);
        next_cycle();
        reset = 1'b0;
        chk("idle_after_reset", O_IDLE);

        // load x5 in execute, decode rs2=5: one bubble, then execute holds the bubble
        next_cycle();
        set_load_use(5'd5, 5'd3, 5'd5);
        chk("load_use_rs2", O_LU);
        next_cycle();
        bus.valid_execute = 1'b0;
        chk("load_use_released", O_IDLE);

        // rs1 match also stalls; a non-load with the same rd does not
        next_cycle();
        set_load_use(5'd7, 5'd7, 5'd0);
        chk("load_use_rs1", O_LU);
        next_cycle();
        bus.load_execute = 1'b0;
        chk("non_load_no_stall", O_IDLE);

        // load to x0 with decode reading x0: no hazard
        next_cycle();
        set_load_use(5'd0, 5'd0, 5'd0);
        chk("x0_no_stall", O_IDLE);

        // taken branch masks a concurrent load-use
        next_cycle();
        set_load_use(5'd9, 5'd9, 5'd1);
        bus.branch_taken = 1'b1;
        chk("branch_masks_load_use", O_BR);

        // exception with taken branch: trap pulse, then FLUSH_CYCLES flush cycles
        next_cycle();
        clear_in();
        bus.exception_memory = 1'b1;
        bus.branch_taken     = 1'b1;
        chk("trap_commit", O_TRAP);
        next_cycle();
        bus.exception_memory = 1'b0;
        bus.branch_taken     = 1'b0;
        bus.mret_memory      = 1'b1;   // ignored while flushing
        chk("trap_flush_1", O_FLUSH);
        next_cycle();
        chk("trap_flush_2", O_FLUSH);
        next_cycle();
        bus.mret_memory = 1'b0;
        chk("trap_back_to_run", O_IDLE);

        // exception and mret together: exception wins
        next_cycle();
        bus.exception_memory = 1'b1;
        bus.mret_memory      = 1'b1;
        chk("exception_beats_mret", O_TRAP);
        next_cycle();
        clear_in();
        next_cycle();
        next_cycle();
        bus.mret_memory = 1'b1;
        chk("mret_commit", O_MRET);
        next_cycle();
        bus.mret_memory = 1'b0;
        chk("mret_flush_1", O_FLUSH);
        next_cycle();
        chk("mret_flush_2", O_FLUSH);
        next_cycle();
        chk("mret_back_to_run", O_IDLE);

        // mem_busy for 4 cycles with load-use waiting, then exactly one bubble
        next_cycle();
        set_load_use(5'd12, 5'd4, 5'd12);
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mem_busy_%0d", i), O_BUSY);
            next_cycle();
        end
        bus.mem_busy = 1'b0;
        chk("busy_then_bubble", O_LU);
        next_cycle();
        bus.valid_execute = 1'b0;
        chk("busy_bubble_done", O_IDLE);

        // wfi with interrupt low: wfi cycle plus 9 sleep cycles low, then high
        next_cycle();
        clear_in();
        bus.wfi_memory = 1'b1;
        chk("wfi_commit", O_FLUSH);
        next_cycle();
        bus.wfi_memory = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("sleep_%0d", i), O_SLEEP);
            next_cycle();
        end
        bus.interrupt_pending = 1'b1;
        chk("sleep_irq_seen", O_SLEEP);
        next_cycle();
        chk("wake_run", O_IDLE);

        // wfi with interrupt already pending stays in RUN
        next_cycle();
        bus.wfi_memory = 1'b1;
        next_cycle();
        bus.wfi_memory = 1'b0;
        chk("wfi_irq_pending_no_sleep", O_IDLE);

        // reset mid-FLUSH (counter=1)
        next_cycle();
        clear_in();
        bus.exception_memory = 1'b1;
        next_cycle();
        bus.exception_memory = 1'b0;
        chk("pre_reset_flush", O_FLUSH);
        #1;
        reset = 1'b1;
        chk("reset_mid_flush", O_RST);
        next_cycle();
        reset = 1'b0;
        chk("run_after_flush_reset", O_IDLE);

        // reset mid-SLEEP drops stalls immediately
        next_cycle();
        bus.wfi_memory = 1'b1;
        next_cycle();
        bus.wfi_memory = 1'b0;
        chk("pre_reset_sleep", O_SLEEP);
        #1;
        reset = 1'b1;
        chk("reset_mid_sleep", O_RST);
        next_cycle();
        reset = 1'b0;
        chk("run_after_sleep_reset", O_IDLE);

        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
